// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer trial sequencer.
// Waits (MIN_DELAY_MS + LFSR sample) ms after a start press, lights the
// stimulus LED, then counts whole milliseconds until the react press.
// False starts (react before the stimulus) and timeouts (count reaching
// MAX_REACT_MS) are flagged. The result is held until the next start.
module reaction_timer_ctrl #(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_REACT_MS = 9999
) (
  input  logic        CLK_50MHZ,
  input  logic        RESET,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic [11:0] random_num,
  output logic        led_stim,
  output logic        busy,
  output logic [13:0] reaction_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout
);

  localparam int              PW       = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [12:0]     MIN_D    = 13'(MIN_DELAY_MS);
  localparam logic [13:0]     MAX_R    = 14'(MAX_REACT_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_STIM,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [12:0]   r_delay;
  logic [13:0]   r_react_ms;
  logic          r_led;
  logic          r_busy;
  logic          r_valid;
  logic          r_false;
  logic          r_timeout;
  logic          w_timing;
  logic          w_tick;
  logic [13:0]   w_react_inc;
  logic          w_sat;

  // The millisecond prescaler only runs while a trial is timing.
  assign w_timing    = (r_state == S_WAIT) || (r_state == S_STIM);
  assign w_tick      = w_timing && (r_presc == PRE_LAST);
  assign w_react_inc = r_react_ms + 14'd1;
  assign w_sat       = (w_react_inc == MAX_R);

  assign led_stim     = r_led;
  assign busy         = r_busy;
  assign reaction_ms  = r_react_ms;
  assign result_valid = r_valid;
  assign false_start  = r_false;
  assign timeout      = r_timeout;

  // State register.
  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; react wins over a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start_btn) w_state_nxt = S_ARM;
      end
      S_ARM: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (react_btn)                        w_state_nxt = S_FAULT;
        else if (w_tick && r_delay == 13'd1)  w_state_nxt = S_STIM;
      end
      S_STIM: begin
        if (react_btn)           w_state_nxt = S_DONE;
        else if (w_tick && w_sat) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler: wraps on tick, held at zero outside WAIT/STIM so that each
  // timed state starts from a fresh millisecond.
  always_ff @(posedge CLK_50MHZ) begin
    if (RESET)                   r_presc <= '0;
    else if (w_timing && !w_tick) r_presc <= r_presc + PW'(1);
    else                          r_presc <= '0;
  end

  // Delay counter, reaction counter and registered status outputs.
  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      r_delay    <= '0;
      r_react_ms <= '0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_false    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_led  <= (w_state_nxt == S_STIM);
      r_busy <= (w_state_nxt == S_ARM) || (w_state_nxt == S_WAIT) ||
                (w_state_nxt == S_STIM);
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          // Previous result is discarded as the new trial arms.
          if (start_btn) begin
            r_react_ms <= '0;
            r_valid    <= 1'b0;
            r_false    <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        S_ARM: begin
          r_delay    <= MIN_D + {1'b0, random_num};
          r_react_ms <= '0;
        end
        S_WAIT: begin
          if (react_btn)                        r_false <= 1'b1;
          else if (w_tick && r_delay != 13'd1)  r_delay <= r_delay - 13'd1;
        end
        S_STIM: begin
          if (react_btn) begin
            r_valid <= 1'b1;
          end else if (w_tick) begin
            r_react_ms <= w_react_inc;
            if (w_sat) r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with CLK_PER_MS=4, MIN_DELAY_MS=2,
// MAX_REACT_MS=20. Each table record applies one input pulse (or none),
// lets n rising edges elapse in total, and then checks all outputs.
module tb_reaction_timer_ctrl;

  localparam int CPM  = 4;
  localparam int MIND = 2;
  localparam int MAXR = 20;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start_btn;
  logic        react_btn;
  logic [11:0] random_num;
  logic        led_stim;
  logic        busy;
  logic [13:0] reaction_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;

  reaction_timer_ctrl #(
    .CLK_PER_MS  (CPM),
    .MIN_DELAY_MS(MIND),
    .MAX_REACT_MS(MAXR)
  ) dut (
    .CLK_50MHZ   (clk),
    .RESET       (RESET),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .random_num  (random_num),
    .led_stim    (led_stim),
    .busy        (busy),
    .reaction_ms (reaction_ms),
    .result_valid(result_valid),
    .false_start (false_start),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rc;
    logic [11:0] rnd;
    int          n;
    logic        e_led;
    logic        e_busy;
    logic [13:0] e_rms;
    logic        e_val;
    logic        e_fs;
    logic        e_to;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic rst, input logic st, input logic rc,
                              input logic [11:0] rnd, input int n,
                              input logic led, input logic bsy,
                              input logic [13:0] rms, input logic val,
                              input logic fs, input logic to);
    vec_t v;
    v.rst = rst; v.st = st; v.rc = rc; v.rnd = rnd; v.n = n;
    v.e_led = led; v.e_busy = bsy; v.e_rms = rms;
    v.e_val = val; v.e_fs = fs; v.e_to = to;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic led, input logic bsy,
                           input logic [13:0] rms, input logic val,
                           input logic fs, input logic to);
    chk({tag, ".led_stim"},     int'(led_stim),     int'(led));
    chk({tag, ".busy"},         int'(busy),         int'(bsy));
    chk({tag, ".reaction_ms"},  int'(reaction_ms),  int'(rms));
    chk({tag, ".result_valid"}, int'(result_valid), int'(val));
    chk({tag, ".false_start"},  int'(false_start),  int'(fs));
    chk({tag, ".timeout"},      int'(timeout),      int'(to));
  endtask

  // Called at a falling edge: drive for one rising edge, then settle at the
  // next falling edge.
  task automatic pulse(input logic rst, input logic st, input logic rc);
    RESET = rst; start_btn = st; react_btn = rc;
    @(posedge clk);
    #1;
    RESET = 1'b0; start_btn = 1'b0; react_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    RESET = 1'b1; start_btn = 1'b0; react_btn = 1'b0; random_num = 12'd5;

    // delay = 2 + 5 = 7 ms -> STIM entered 1 + 7*4 = 29 edges after start.
    //   rst st rc rnd  n    led bsy rms val fs to
    add(1, 0, 0, 5,   1,   0, 0,  0, 0, 0, 0); // reset state
    add(0, 0, 0, 5,   3,   0, 0,  0, 0, 0, 0); // idle stays idle
    add(0, 1, 0, 5,   1,   0, 1,  0, 0, 0, 0); // start: busy on next edge
    add(0, 0, 0, 5,  28,   0, 1,  0, 0, 0, 0); // edge 28: still waiting
    add(0, 0, 0, 5,   1,   1, 1,  0, 0, 0, 0); // edge 29: stimulus
    add(0, 0, 0, 5,  40,   1, 1, 10, 0, 0, 0); // 10 ticks counted
    add(0, 0, 0, 5,   1,   1, 1, 10, 0, 0, 0); // 41 cycles after stimulus
    add(0, 0, 1, 5,   1,   0, 0, 10, 1, 0, 0); // react 42 cycles after
    add(0, 0, 0, 5, 100,   0, 0, 10, 1, 0, 0); // result held
    // False start
    add(0, 1, 0, 5,   2,   0, 1,  0, 0, 0, 0); // re-armed, result cleared
    add(0, 0, 0, 5,   5,   0, 1,  0, 0, 0, 0);
    add(0, 0, 1, 5,   1,   0, 0,  0, 0, 1, 0); // react in WAIT
    add(0, 0, 0, 5,  40,   0, 0,  0, 0, 1, 0); // stimulus never lights
    add(0, 1, 0, 5,   2,   0, 1,  0, 0, 0, 0); // start clears false_start
    // Ignored starts in WAIT and STIM, react coincident with tick
    add(0, 0, 0, 5,  10,   0, 1,  0, 0, 0, 0); // edge 11
    add(0, 1, 0, 5,   1,   0, 1,  0, 0, 0, 0); // start in WAIT, edge 12
    add(0, 0, 0, 5,  17,   1, 1,  0, 0, 0, 0); // stimulus still at edge 29
    add(0, 0, 0, 5,  19,   1, 1,  4, 0, 0, 0); // edge 48
    add(0, 1, 0, 5,   1,   1, 1,  5, 0, 0, 0); // start in STIM on a tick
    add(0, 0, 0, 5,  19,   1, 1,  9, 0, 0, 0); // edge 68
    add(0, 0, 1, 5,   1,   0, 0,  9, 1, 0, 0); // react on 10th tick: excluded
    // Timeout
    add(0, 1, 0, 5,   2,   0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,  28,   1, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,  79,   1, 1, 19, 0, 0, 0);
    add(0, 0, 0, 5,   1,   0, 0, 20, 0, 0, 1); // 80 cycles of STIM
    add(0, 0, 0, 5,  20,   0, 0, 20, 0, 0, 1);
    // Reset during STIM, then a full trial
    add(0, 1, 0, 5,   2,   0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,  28,   1, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,  10,   1, 1,  2, 0, 0, 0);
    add(1, 0, 0, 5,   1,   0, 0,  0, 0, 0, 0); // abort
    add(0, 1, 0, 5,   1,   0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,  28,   0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,   1,   1, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,   8,   1, 1,  2, 0, 0, 0);
    add(0, 0, 1, 5,   1,   0, 0,  2, 1, 0, 0);
    // Reset during WAIT, then a trial with random_num=1 (delay 3 ms)
    add(0, 1, 0, 5,   2,   0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 5,  10,   0, 1,  0, 0, 0, 0);
    add(1, 0, 0, 5,   1,   0, 0,  0, 0, 0, 0); // abort
    add(0, 0, 0, 5,   5,   0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 1,   1,   0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 1,  12,   0, 1,  0, 0, 0, 0); // edge 12
    add(0, 0, 0, 1,   1,   1, 1,  0, 0, 0, 0); // edge 13 = 1 + 3*4
    add(0, 0, 1, 1,   1,   0, 0,  0, 1, 0, 0); // immediate react -> 0 ms

    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (vq[i]) begin
      random_num = vq[i].rnd;
      RESET = vq[i].rst; start_btn = vq[i].st; react_btn = vq[i].rc;
      @(posedge clk);
      #1;
      RESET = 1'b0; start_btn = 1'b0; react_btn = 1'b0;
      repeat (vq[i].n - 1) @(posedge clk);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vq[i].e_led, vq[i].e_busy,
                vq[i].e_rms, vq[i].e_val, vq[i].e_fs, vq[i].e_to);
    end

    // Full trial, result checked every cycle for 100 cycles after react.
    random_num = 12'd5;
    pulse(1'b0, 1'b1, 1'b0);
    idle(28);
    chk("seqA.led_before", int'(led_stim), 0);
    idle(1);
    chk("seqA.led_rise", int'(led_stim), 1);
    idle(41);
    pulse(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      check_all($sformatf("seqA.hold%0d", c), 1'b0, 1'b0, 14'd10, 1'b1, 1'b0, 1'b0);
      idle(1);
    end

    // False start late in WAIT; the LED must stay dark every cycle after.
    pulse(1'b0, 1'b1, 1'b0);
    idle(20);
    pulse(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      chk($sformatf("seqB.led%0d", c), int'(led_stim), 0);
      chk($sformatf("seqB.fs%0d", c), int'(false_start), 1);
      idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
